// File: rtl/vec_alu_seq.sv
// vec_alu_seq: multi-cycle, lane-parallel vector integer ALU with valid/ready handshakes.
// Define VECALU_MASK_EN to add the vm/mask ports and per-element masking.
module vec_alu_seq #(
   parameter int VLEN  = 64,
   parameter int ELEN  = 32,
   parameter int LANES = 8,
   parameter int VLW   = $clog2(VLEN + 1)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [3:0]      op,
   input  logic [VLW-1:0]  vl,
`ifdef VECALU_MASK_EN
   input  logic            vm,
   input  logic [VLEN-1:0] mask,
`endif
   input  logic [ELEN-1:0] src1 [0:VLEN-1],
   input  logic [ELEN-1:0] src2 [0:VLEN-1],
   output logic            out_valid,
   input  logic            out_ready,
   output logic [ELEN-1:0] result [0:VLEN-1]
);

   localparam int NG = VLEN / LANES;
   localparam int GW = (NG > 1) ? $clog2(NG) : 1;
   localparam int IW = (VLEN > 1) ? $clog2(VLEN) : 1;
   localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
   localparam int SW = (ELEN > 1) ? $clog2(ELEN) : 1;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE
   } state_t;

   typedef enum logic [3:0] {
      OP_ADD  = 4'd0,
      OP_SUB  = 4'd1,
      OP_AND  = 4'd2,
      OP_OR   = 4'd3,
      OP_XOR  = 4'd4,
      OP_SLL  = 4'd5,
      OP_SRL  = 4'd6,
      OP_SLT  = 4'd7,
      OP_SRA  = 4'd8,
      OP_SLTU = 4'd9,
      OP_MIN  = 4'd10,
      OP_MAX  = 4'd11
   } op_t;

   state_t          state;
   logic [GW-1:0]   grp;
   logic [3:0]      op_q;
   logic [VLW-1:0]  vl_q;
   logic [ELEN-1:0] s2_q [0:VLEN-1];
`ifdef VECALU_MASK_EN
   logic            vm_q;
   logic [VLEN-1:0] mask_q;
`endif

   logic [IW-1:0]   lane_idx [0:LANES-1];
   logic            lane_we  [0:LANES-1];
   logic [ELEN-1:0] lane_res [0:LANES-1];
   logic            accept;
   logic            last_grp;
   logic [VLW-1:0]  vl_clamped;

   function automatic logic [ELEN-1:0] alu(input logic [3:0] f,
                                           input logic [ELEN-1:0] a,
                                           input logic [ELEN-1:0] b);
      logic [SW-1:0] sh;
      sh = b[SW-1:0];
      case (op_t'(f))
         OP_ADD:  alu = a + b;
         OP_SUB:  alu = a - b;
         OP_AND:  alu = a & b;
         OP_OR:   alu = a | b;
         OP_XOR:  alu = a ^ b;
         OP_SLL:  alu = a << sh;
         OP_SRL:  alu = a >> sh;
         OP_SRA:  alu = $signed(a) >>> sh;
         OP_SLT:  alu = {{(ELEN-1){1'b0}}, ($signed(a) < $signed(b))};
         OP_SLTU: alu = {{(ELEN-1){1'b0}}, (a < b)};
         OP_MIN:  alu = ($signed(a) < $signed(b)) ? a : b;
         OP_MAX:  alu = ($signed(a) < $signed(b)) ? b : a;
         default: alu = '0;
      endcase
   endfunction

   assign accept     = (state == IDLE) && in_valid;
   assign vl_clamped = (vl > VLW'(VLEN)) ? VLW'(VLEN) : vl;
   assign last_grp   = ((32'(grp) + 32'd1) * 32'(LANES)) >= 32'(vl_q);

   // Operand A comes from result: it is preloaded with src1 and each element is written once.
   always_comb begin
      for (int unsigned l = 0; l < LANES; l++) begin
         lane_idx[l] = IW'(32'(grp) * 32'(LANES) + l);
`ifdef VECALU_MASK_EN
         lane_we[l]  = ((32'(grp) * 32'(LANES) + l) < 32'(vl_q)) &&
                       (!vm_q || mask_q[lane_idx[l]]);
`else
         lane_we[l]  = (32'(grp) * 32'(LANES) + l) < 32'(vl_q);
`endif
         lane_res[l] = alu(op_q, result[lane_idx[l]], s2_q[lane_idx[l]]);
      end
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         op_q <= op;
         vl_q <= vl_clamped;
         for (int unsigned j = 0; j < VLEN; j++) begin
            s2_q[j] <= src2[j];
         end
`ifdef VECALU_MASK_EN
         vm_q   <= vm;
         mask_q <= mask;
`endif
      end
   end

   // vl = 0 still spends one BUSY cycle (no writes) so out_valid never rises on the accept edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         grp       <= '0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         for (int unsigned j = 0; j < VLEN; j++) begin
            result[j] <= '0;
         end
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  grp      <= '0;
                  in_ready <= 1'b0;
                  state    <= BUSY;
                  for (int unsigned j = 0; j < VLEN; j++) begin
                     result[j] <= src1[j];
                  end
               end
            end
            BUSY: begin
               for (int unsigned j = 0; j < VLEN; j++) begin
                  if ((GW'(j / LANES) == grp) && lane_we[LW'(j % LANES)]) begin
                     result[j] <= lane_res[LW'(j % LANES)];
                  end
               end
               if (last_grp) begin
                  state     <= DONE;
                  out_valid <= 1'b1;
               end else begin
                  grp <= grp + GW'(1);
               end
            end
            DONE: begin
               if (out_ready) begin
                  state     <= IDLE;
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
               end
            end
            default: begin
               state     <= IDLE;
               out_valid <= 1'b0;
               in_ready  <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_vec_alu_seq.sv
// Self-checking bench for vec_alu_seq: directed table, corner-case sequences and random ops
// checked against an arithmetic reference model. Mask cases run when VECALU_MASK_EN is defined.
module tb_vec_alu_seq;

   localparam int VLEN  = 64;
   localparam int ELEN  = 32;
   localparam int LANES = 8;
   localparam int VLW   = 7;

   logic            clk = 1'b0;
   logic            rst;
   logic            in_valid;
   logic            in_ready;
   logic [3:0]      op;
   logic [VLW-1:0]  vl;
`ifdef VECALU_MASK_EN
   logic            vm;
   logic [VLEN-1:0] mask;
`endif
   logic [ELEN-1:0] src1 [0:VLEN-1];
   logic [ELEN-1:0] src2 [0:VLEN-1];
   logic            out_valid;
   logic            out_ready;
   logic [ELEN-1:0] result [0:VLEN-1];

   always #5 clk = ~clk;

   vec_alu_seq #(.VLEN(VLEN), .ELEN(ELEN), .LANES(LANES), .VLW(VLW)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .op(op), .vl(vl),
`ifdef VECALU_MASK_EN
      .vm(vm), .mask(mask),
`endif
      .src1(src1), .src2(src2), .out_valid(out_valid), .out_ready(out_ready),
      .result(result)
   );

   int passed = 0;
   int total  = 0;
   logic [31:0] a_arr [64];
   logic [31:0] b_arr [64];
   logic [31:0] exp_arr [64];

   typedef struct {
      int          f;
      int          vl;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] y;
   } vec_t;
   vec_t tbl [14];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic chk_vec(input string name);
      int bad = -1;
      for (int i = 0; i < 64; i++)
         if (bad < 0 && result[i] !== exp_arr[i]) bad = i;
      total++;
      if (bad < 0) passed++;
      else $display("FAIL %s: result[%0d] got %h expected %h", name, bad, result[bad], exp_arr[bad]);
   endtask

   function automatic logic [31:0] ref_elem(input int f, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb, p, q;
      int     sh;
      sa = $signed(a);
      sb = $signed(b);
      sh = int'(b % 32);
      p  = longint'(1) << sh;
      case (f)
         0:  return 32'(longint'(a) + longint'(b));
         1:  return 32'(longint'(a) - longint'(b));
         2:  return a & b;
         3:  return a | b;
         4:  return a ^ b;
         5:  return 32'(longint'(a) * p);
         6:  return 32'(longint'(a) / p);
         7:  return (sa < sb) ? 32'd1 : 32'd0;
         8: begin
            if (sa >= 0) q = sa / p;
            else         q = -((-sa - 1) / p) - 1;
            return 32'(q);
         end
         9:  return (a < b) ? 32'd1 : 32'd0;
         10: return (sa < sb) ? a : b;
         11: return (sa > sb) ? a : b;
         default: return 32'd0;
      endcase
   endfunction

   task automatic model_vec(input int f, input int vln, input logic vmi, input logic [63:0] mk);
      int vlc = (vln > 64) ? 64 : vln;
      for (int i = 0; i < 64; i++)
         exp_arr[i] = (i < vlc && (!vmi || mk[i])) ? ref_elem(f, a_arr[i], b_arr[i]) : a_arr[i];
   endtask

   task automatic start_op(input int f, input int vln, input logic vmi, input logic [63:0] mk);
      int n = 0;
      @(negedge clk);
      while (!in_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("accept_ready", in_ready, 1);
      op = 4'(f);
      vl = VLW'(vln);
      for (int i = 0; i < 64; i++) begin
         src1[i] = a_arr[i];
         src2[i] = b_arr[i];
      end
`ifdef VECALU_MASK_EN
      vm   = vmi;
      mask = mk;
`endif
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      op = 4'($urandom);
      vl = VLW'($urandom);
      for (int i = 0; i < 64; i++) begin
         src1[i] = $urandom;
         src2[i] = $urandom;
      end
      model_vec(f, vln, vmi, mk);
   endtask

   task automatic wait_check(input string name, input int vln);
      int lat = 0;
      int vlc = (vln > 64) ? 64 : vln;
      int el  = (vlc == 0) ? 1 : (vlc + 7) / 8;
      while (!out_valid && lat < 100) begin
         @(posedge clk);
         #1;
         lat++;
      end
      chk({name, "_latency"}, lat, el);
      chk_vec({name, "_result"});
   endtask

   task automatic finish_op(input string name);
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      chk({name, "_valid_drop"}, out_valid, 0);
      chk({name, "_ready_back"}, in_ready, 1);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: run did not finish, %0d/%0d passed so far", passed, total);
      $fatal(1, "watchdog");
   end

   initial begin
      tbl[0]  = '{0,  64,  32'd5,          32'd7,          32'd12};
      tbl[1]  = '{1,  17,  32'd3,          32'd5,          32'hFFFF_FFFE};
      tbl[2]  = '{2,  8,   32'hF0F0_1234,  32'h0FF0_FFFF,  32'h00F0_1234};
      tbl[3]  = '{3,  9,   32'hF000_0000,  32'h0000_000F,  32'hF000_000F};
      tbl[4]  = '{4,  64,  32'hFFFF_0000,  32'h0F0F_0F0F,  32'hF0F0_0F0F};
      tbl[5]  = '{5,  33,  32'd1,          32'd31,         32'h8000_0000};
      tbl[6]  = '{6,  40,  32'h8000_0000,  32'd36,         32'h0800_0000};
      tbl[7]  = '{7,  16,  32'hFFFF_FFFF,  32'd1,          32'd1};
      tbl[8]  = '{8,  64,  32'hF000_0000,  32'd36,         32'hFF00_0000};
      tbl[9]  = '{9,  7,   32'hFFFF_FFFF,  32'd1,          32'd0};
      tbl[10] = '{10, 24,  32'hFFFF_FFFD,  32'd2,          32'hFFFF_FFFD};
      tbl[11] = '{11, 1,   32'hFFFF_FFFD,  32'd2,          32'd2};
      tbl[12] = '{13, 56,  32'd1234,       32'd5678,       32'd0};
      tbl[13] = '{0,  100, 32'd1,          32'd1,          32'd2};

      rst = 1'b1;
      in_valid = 1'b0;
      out_ready = 1'b0;
      op = '0;
      vl = '0;
`ifdef VECALU_MASK_EN
      vm = 1'b0;
      mask = '0;
`endif
      for (int i = 0; i < 64; i++) begin
         src1[i] = '0;
         src2[i] = '0;
         exp_arr[i] = '0;
      end
      repeat (2) @(negedge clk);
      chk_vec("reset_result");
      chk("reset_out_valid", out_valid, 0);
      rst = 1'b0;
      #1;
      chk("reset_in_ready", in_ready, 1);

      for (int t = 0; t < 14; t++) begin
         for (int i = 0; i < 64; i++) begin
            a_arr[i] = tbl[t].a;
            b_arr[i] = tbl[t].b;
         end
         start_op(tbl[t].f, tbl[t].vl, 1'b0, '0);
         for (int i = 0; i < 64; i++)
            exp_arr[i] = (i < tbl[t].vl) ? tbl[t].y : tbl[t].a;
         wait_check($sformatf("tbl%0d", t), tbl[t].vl);
         finish_op($sformatf("tbl%0d", t));
      end

      for (int i = 0; i < 64; i++) begin
         a_arr[i] = 32'(i);
         b_arr[i] = 32'hFFFF_FFFF;
      end
      start_op(0, 64, 1'b0, '0);
      for (int i = 0; i < 64; i++) exp_arr[i] = 32'(i) - 32'd1;
      wait_check("add_full", 64);
      finish_op("add_full");

      for (int i = 0; i < 64; i++) begin
         a_arr[i] = 32'd100;
         b_arr[i] = 32'(i);
      end
      start_op(1, 5, 1'b0, '0);
      for (int i = 0; i < 64; i++) exp_arr[i] = (i < 5) ? 32'(100 - i) : 32'd100;
      wait_check("sub_tail", 5);
      finish_op("sub_tail");

`ifdef VECALU_MASK_EN
      for (int i = 0; i < 64; i++) begin
         a_arr[i] = 32'h0000_FFFF;
         b_arr[i] = 32'h0000_00FF;
      end
      start_op(2, 64, 1'b1, 64'h5555_5555_5555_5555);
      for (int i = 0; i < 64; i++) exp_arr[i] = (i % 2 == 0) ? 32'h00FF : 32'hFFFF;
      wait_check("mask_and", 64);
      finish_op("mask_and");
`endif

      for (int i = 0; i < 64; i++) begin
         a_arr[i] = $urandom;
         b_arr[i] = $urandom;
      end
      start_op(0, 64, 1'b0, '0);
      wait_check("bp_op", 64);
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         in_valid = 1'b1;
         op = 4'd1;
         vl = 7'd3;
         for (int i = 0; i < 64; i++) src1[i] = $urandom;
         @(posedge clk);
         #1;
         chk("bp_out_valid", out_valid, 1);
         chk("bp_in_ready", in_ready, 0);
         chk_vec("bp_stable");
      end
      for (int i = 0; i < 64; i++) begin
         a_arr[i] = $urandom;
         b_arr[i] = $urandom;
      end
      @(negedge clk);
      op = 4'd4;
      vl = '0;
      for (int i = 0; i < 64; i++) begin
         src1[i] = a_arr[i];
         src2[i] = b_arr[i];
      end
      in_valid = 1'b1;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      chk("bp_release_valid", out_valid, 0);
      chk("bp_release_ready", in_ready, 1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      chk("bp_next_accept", in_ready, 0);
      for (int i = 0; i < 64; i++) exp_arr[i] = a_arr[i];
      wait_check("vl0", 0);
      finish_op("vl0");

      for (int i = 0; i < 64; i++) begin
         a_arr[i] = $urandom;
         b_arr[i] = $urandom;
      end
      start_op(0, 64, 1'b0, '0);
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      chk("rst_mid_out_valid", out_valid, 0);
      for (int i = 0; i < 64; i++) exp_arr[i] = '0;
      chk_vec("rst_mid_result");
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rst_mid_in_ready", in_ready, 1);
      repeat (10) @(posedge clk);
      #1;
      chk("rst_mid_discarded", out_valid, 0);
      start_op(11, 30, 1'b0, '0);
      wait_check("post_rst", 30);
      finish_op("post_rst");

      for (int r = 0; r < 25; r++) begin
         int          f   = int'($urandom_range(0, 13));
         int          vln = int'($urandom_range(0, 72));
         logic        vmi = 1'b0;
         logic [63:0] mk  = {$urandom, $urandom};
`ifdef VECALU_MASK_EN
         vmi = 1'($urandom);
`endif
         for (int i = 0; i < 64; i++) begin
            a_arr[i] = $urandom;
            b_arr[i] = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 40));
         end
         start_op(f, vln, vmi, mk);
         wait_check($sformatf("rand%0d_op%0d_vl%0d", r, f, vln), vln);
         finish_op($sformatf("rand%0d", r));
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
